// File: rtl/debounce_array_pkg.sv
// Shared types for the debounce array: per-channel auto-repeat state encoding.
package debounce_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchroniser, saturating integrator with hysteresis,
// edge pulses and an auto-repeat timer FSM.
module debounce_channel
    import debounce_array_pkg::*;
#(
    parameter int WIDTH         = 20,
    parameter int TWIDTH        = 24,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam logic [WIDTH-1:0]  CNT_MAX     = '1;
    localparam logic [TWIDTH-1:0] DELAY_LAST  = TWIDTH'(REPEAT_DELAY - 1);
    localparam logic [TWIDTH-1:0] PERIOD_LAST = TWIDTH'(REPEAT_PERIOD - 1);

    logic              s1_reg;
    logic              s2_reg;
    logic [WIDTH-1:0]  cnt_reg;
    logic [WIDTH-1:0]  cnt_next;
    logic              level_reg;
    logic              level_next;
    logic              press_reg;
    logic              release_reg;
    logic              repeat_reg;
    logic [TWIDTH-1:0] timer_reg;
    rep_state_t        state_reg;
    logic              rise;
    logic              fall;

    // Level only moves when the integrator sits at an extreme, which gives hysteresis.
    always_comb begin
        cnt_next = cnt_reg;
        if (s2_reg && (cnt_reg != CNT_MAX))
            cnt_next = cnt_reg + WIDTH'(1);
        else if (!s2_reg && (cnt_reg != '0))
            cnt_next = cnt_reg - WIDTH'(1);

        level_next = level_reg;
        if (s2_reg && (cnt_reg == CNT_MAX))
            level_next = 1'b1;
        else if (!s2_reg && (cnt_reg == '0))
            level_next = 1'b0;

        rise = level_next & ~level_reg;
        fall = ~level_next & level_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
            timer_reg   <= '0;
            state_reg   <= ST_IDLE;
        end else begin
            s1_reg      <= raw;
            s2_reg      <= s1_reg;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            press_reg   <= rise;
            release_reg <= fall;
            repeat_reg  <= 1'b0;

            // Release wins over any repeat due in the same cycle.
            if (fall) begin
                state_reg <= ST_IDLE;
                timer_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rise) begin
                            state_reg <= ST_DELAY;
                            timer_reg <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (!repeat_en) begin
                            timer_reg <= '0;
                        end else if (timer_reg == DELAY_LAST) begin
                            repeat_reg <= 1'b1;
                            state_reg  <= ST_REPEAT;
                            timer_reg  <= '0;
                        end else begin
                            timer_reg <= timer_reg + TWIDTH'(1);
                        end
                    end
                    ST_REPEAT: begin
                        // Disabling repeat falls back so re-enabling waits the full delay.
                        if (!repeat_en) begin
                            state_reg <= ST_DELAY;
                            timer_reg <= '0;
                        end else if (timer_reg == PERIOD_LAST) begin
                            repeat_reg <= 1'b1;
                            timer_reg  <= '0;
                        end else begin
                            timer_reg <= timer_reg + TWIDTH'(1);
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        timer_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign level         = level_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign repeat_pulse  = repeat_reg;

endmodule

// File: rtl/debounce_array.sv
// Array of independent debounced inputs with press/release/auto-repeat pulses.
module debounce_array
    import debounce_array_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 20,
    parameter int TWIDTH        = 24,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            debounce_channel #(
                .WIDTH        (WIDTH),
                .TWIDTH       (TWIDTH),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .raw          (raw[gi]),
                .repeat_en    (repeat_en[gi]),
                .level        (level[gi]),
                .press        (press[gi]),
                .release_pulse(release_pulse[gi]),
                .repeat_pulse (repeat_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array with WIDTH=4 (level change 18 edges after input change).
module tb_debounce_array;

    logic       clk;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] repeat_en;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] repeat_pulse;

    int total = 0;
    int bad   = 0;

    logic       sticky_clr;
    logic [3:0] sticky_press;
    logic [3:0] sticky_rel;

    debounce_array #(
        .CHANNELS     (4),
        .WIDTH        (4),
        .TWIDTH       (8),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw          (raw),
        .repeat_en    (repeat_en),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sticky_clr) begin
            sticky_press <= '0;
            sticky_rel   <= '0;
        end else begin
            sticky_press <= sticky_press | press;
            sticky_rel   <= sticky_rel | release_pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst        = 1'b1;
        raw        = '0;
        repeat_en  = '0;
        sticky_clr = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_level",   32'(level), 32'h0);
        check("reset_press",   32'(press), 32'h0);
        check("reset_release", 32'(release_pulse), 32'h0);
        check("reset_repeat",  32'(repeat_pulse), 32'h0);

        // Clean press and release on ch0.
        raw[0] = 1'b1;
        tick(17);
        check("ch0_lvl_e17",   32'(level), 32'h0);
        tick(1);
        check("ch0_lvl_e18",   32'(level), 32'h1);
        check("ch0_press_e18", 32'(press), 32'h1);
        tick(1);
        check("ch0_press_e19", 32'(press), 32'h0);
        check("ch0_lvl_e19",   32'(level), 32'h1);
        tick(5);
        check("ch0_no_repeat", 32'(repeat_pulse), 32'h0);
        raw[0] = 1'b0;
        tick(17);
        check("ch0_rel_lvl_e17", 32'(level), 32'h1);
        tick(1);
        check("ch0_rel_lvl_e18", 32'(level), 32'h0);
        check("ch0_rel_e18",     32'(release_pulse), 32'h1);
        tick(1);
        check("ch0_rel_e19",     32'(release_pulse), 32'h0);

        // Glitch and bounce on ch1: no pulses or level change.
        sticky_clr = 1'b0;
        raw[1] = 1'b1;
        tick(5);
        raw[1] = 1'b0;
        tick(30);
        check("ch1_glitch_lvl", 32'(level), 32'h0);
        for (int i = 0; i < 100; i++) begin
            raw[1] = ~raw[1];
            tick(1);
        end
        raw[1] = 1'b0;
        tick(30);
        check("ch1_bounce_lvl",   32'(level), 32'h0);
        check("ch1_sticky_press", 32'(sticky_press), 32'h0);
        check("ch1_sticky_rel",   32'(sticky_rel), 32'h0);
        sticky_clr = 1'b1;

        // Auto-repeat on ch2, held with repeat enabled.
        repeat_en[2] = 1'b1;
        raw[2] = 1'b1;
        tick(18);
        check("ch2_press_P",  32'(press), 32'h4);
        tick(9);
        check("ch2_rep_P9",   32'(repeat_pulse), 32'h0);
        tick(1);
        check("ch2_rep_P10",  32'(repeat_pulse), 32'h4);
        tick(1);
        check("ch2_rep_P11",  32'(repeat_pulse), 32'h0);
        tick(2);
        check("ch2_rep_P13",  32'(repeat_pulse), 32'h0);
        tick(1);
        check("ch2_rep_P14",  32'(repeat_pulse), 32'h4);
        tick(4);
        check("ch2_rep_P18",  32'(repeat_pulse), 32'h4);
        tick(2);
        raw[2] = 1'b0;
        // Release lands on P+38, where a repeat would otherwise fire.
        tick(17);
        check("ch2_rel_P37",  32'(release_pulse), 32'h0);
        tick(1);
        check("ch2_rel_P38",  32'(release_pulse), 32'h4);
        check("ch2_rep_P38",  32'(repeat_pulse), 32'h0);
        check("ch2_lvl_P38",  32'(level), 32'h0);
        tick(5);
        check("ch2_idle_rep", 32'(repeat_pulse), 32'h0);

        // Auto-repeat on ch2 with repeat_en dropped for one cycle after P+12.
        raw[2] = 1'b1;
        tick(18);
        check("ch2b_press_P",  32'(press), 32'h4);
        tick(10);
        check("ch2b_rep_P10",  32'(repeat_pulse), 32'h4);
        tick(2);
        repeat_en[2] = 1'b0;
        tick(1);
        repeat_en[2] = 1'b1;
        tick(1);
        check("ch2b_rep_P14",  32'(repeat_pulse), 32'h0);
        tick(8);
        check("ch2b_rep_P22",  32'(repeat_pulse), 32'h0);
        tick(1);
        check("ch2b_rep_P23",  32'(repeat_pulse), 32'h4);
        tick(3);
        check("ch2b_rep_P26",  32'(repeat_pulse), 32'h0);
        tick(1);
        check("ch2b_rep_P27",  32'(repeat_pulse), 32'h4);
        raw[2]       = 1'b0;
        repeat_en[2] = 1'b0;
        tick(18);
        check("ch2b_rel",      32'(release_pulse), 32'h4);

        // Reset mid-hold on ch3 while in the repeat phase.
        repeat_en[3] = 1'b1;
        raw[3] = 1'b1;
        tick(18);
        check("ch3_press",     32'(press), 32'h8);
        tick(12);
        check("ch3_lvl_held",  32'(level), 32'h8);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_level",   32'(level), 32'h0);
        check("rst_mid_press",   32'(press), 32'h0);
        check("rst_mid_release", 32'(release_pulse), 32'h0);
        check("rst_mid_repeat",  32'(repeat_pulse), 32'h0);
        #2;
        rst = 1'b0;
        tick(17);
        check("ch3_repress_e17", 32'(press), 32'h0);
        tick(1);
        check("ch3_repress_e18", 32'(press), 32'h8);
        check("ch3_relvl_e18",   32'(level), 32'h8);
        raw[3]       = 1'b0;
        repeat_en[3] = 1'b0;
        tick(18);
        check("ch3_rel",         32'(release_pulse), 32'h8);

        // Simultaneous press and release on ch0 and ch1.
        raw[1:0] = 2'b11;
        tick(18);
        check("conc_press",   32'(press), 32'h3);
        check("conc_level",   32'(level), 32'h3);
        tick(1);
        check("conc_press_1", 32'(press), 32'h0);
        raw[1:0] = 2'b00;
        tick(18);
        check("conc_release", 32'(release_pulse), 32'h3);
        check("conc_lvl_off", 32'(level), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels.
REQ-002 Parameter WIDTH, default 20: integrator counter width per channel; full scale is 2^WIDTH-1.
REQ-003 Parameter TWIDTH, default 24: repeat-timer width per channel.
REQ-004 Parameter REPEAT_DELAY, default 5000000: cycles from press to first repeat pulse; legal range 1 to 2^TWIDTH-1.
REQ-005 Parameter REPEAT_PERIOD, default 1000000: cycles between subsequent repeat pulses; legal range 1 to 2^TWIDTH-1.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 raw  input  CHANNELS  asynchronous noisy inputs, one bit per channel.
REQ-009 repeat_en  input  CHANNELS  per-channel auto-repeat enable, synchronous to clk.
REQ-010 level  output  CHANNELS  debounced registered level.
REQ-011 press  output  CHANNELS  one-cycle pulse on level 0->1.
REQ-012 release  output  CHANNELS  one-cycle pulse on level 1->0.
REQ-013 repeat  output  CHANNELS  one-cycle auto-repeat pulse while held.

Function
REQ-014 Each raw bit SHALL pass a 2-flop synchroniser (s1, s2) before any other use.
REQ-015 Integrator: when s2=1 and cnt<max, cnt+1; when s2=0 and cnt>0, cnt-1; otherwise hold. No wrap in either direction.
REQ-016 Level: when s2=1 and cnt=max, level<=1; when s2=0 and cnt=0, level<=0; otherwise hold (hysteresis; level only changes at the counter extremes).
REQ-017 With raw stable after a change and cnt starting at the opposite extreme, level SHALL change on the (2^WIDTH+2)-th clock edge after the raw change.
REQ-018 press and release SHALL be registered and asserted in the same cycle that level changes, for exactly one cycle.
REQ-019 Per-channel FSM: IDLE (level=0), DELAY, REPEAT. IDLE->DELAY on press, timer cleared.
REQ-020 In DELAY with repeat_en=1, the timer SHALL increment each cycle. repeat pulses when the timer reaches REPEAT_DELAY, i.e. REPEAT_DELAY cycles after press. The FSM then enters REPEAT and the timer clears.
REQ-021 In REPEAT with repeat_en=1, repeat SHALL pulse every REPEAT_PERIOD cycles.
REQ-022 When repeat_en=0 in DELAY or REPEAT, the timer clears and the FSM returns to DELAY. No repeat pulses occur; re-enabling restarts the full REPEAT_DELAY.
REQ-023 Release (level 1->0) SHALL return any state to IDLE. repeat SHALL NOT assert in the release cycle.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-025 rst=1 SHALL clear the following immediately, without a clock edge: s1, s2, cnt, timer, level, press, release, repeat (all 0) and FSM (IDLE).
REQ-026 After rst deasserts with raw held high, the channel SHALL behave as a fresh press (press pulse after 2^WIDTH+2 edges).

Structure
REQ-027 FSM state encodings (IDLE, DELAY, REPEAT) SHALL live in the shared package/header.
REQ-028 One sub-module, debounce_channel, SHALL implement one channel (synchroniser, integrator, FSM, timer). The top SHALL instantiate CHANNELS copies via generate.

Verification (CHANNELS=4, WIDTH=4, TWIDTH=8, REPEAT_DELAY=10, REPEAT_PERIOD=4)
REQ-029 Reset: assert rst mid-cycle -> all outputs 0 before the next clk edge.
REQ-030 Clean press ch0: raw[0] 0->1 held -> level[0]=1 and press[0] one-cycle pulse at edge 18. raw[0] 1->0 held -> level[0]=0 and release[0] pulse 18 edges later.
REQ-031 Glitch/bounce ch1: raw[1] high 5 cycles then low, and separately raw[1] toggling every cycle for 100 cycles -> level[1], press[1] and release[1] stay 0.
REQ-032 Auto-repeat ch2: repeat_en[2]=1, press at edge P -> repeat[2] at P+10, P+14, P+18. Dropping repeat_en[2] at P+12 for 1 cycle -> next pulses at P+23, P+27.
REQ-033 Reset mid-hold ch3: level[3]=1 in REPEAT, pulse rst with raw[3] still high -> outputs 0 at once. press[3] reappears 18 edges after rst deasserts.
REQ-034 Concurrency: ch0 and ch1 pressed on the same edge -> press[0] and press[1] pulse in the same cycle. ch2/ch3 are unaffected.
